memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Memory (MEM) pipeline stage of the 16-bit CPU. It consumes the outputs of the EX/MEM pipeline register and performs the load or store against the data memory over a request/acknowledge handshake. It stalls the upstream pipeline while an access is outstanding and aborts any access that exceeds a timeout. The block contains the MEM/WB pipeline register that feeds the writeback stage.

## Interface

Parameters:
- DATA_W, 16, data and address width
- TIMEOUT, 15, maximum number of ACCESS cycles without acknowledge before the access is aborted (≥1)

Ports (one per line: name, direction, width, meaning):
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- wbs_in  in  1  writeback-select from EX/MEM, forwarded to writeback
- wme_in  in  1  store request (write memory enable)
- mm_in  in  1  load request; selects memory data as the writeback value
- wm_in  in  1  register-file write enable for this instruction
- ni_in  in  1  no-instruction (bubble) flag; 1 means the slot is empty
- ALUresult_in  in  DATA_W  memory address, or pass-through result
- memData_in  in  DATA_W  store data
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  DATA_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack=1
- mem_ack  in  1  one-cycle completion pulse from memory
- stall  out  1  holds the EX/MEM register and every earlier stage
- wbs_out  out  1  MEM/WB writeback-select
- wm_out  out  1  MEM/WB register-file write enable
- ni_out  out  1  MEM/WB bubble flag
- wb_data  out  DATA_W  MEM/WB writeback value
- err_timeout  out  1  sticky flag, set by an aborted access

## Operation

- A slot is a memory operation when ni_in=0 and (wme_in=1 or mm_in=1). If wme_in=1 and mm_in=1, the slot is a store, and wb_data = ALUresult_in.
- FSM has two states:
  - IDLE → ACCESS when the input slot is a memory operation. On that edge: mem_req←1, mem_we←wme_in, mem_addr←ALUresult_in, mem_wdata←memData_in, counter←0.
  - ACCESS → IDLE when mem_ack=1. On that edge:
    - mem_req←0.
    - The MEM/WB register captures the instruction. A load gives wb_data=mem_rdata; a store gives wb_data=ALUresult_in. wm_out=wm_in, wbs_out=wbs_in, ni_out=0.
  - ACCESS → IDLE on timeout. The timeout fires when counter==TIMEOUT-1 and mem_ack=0. On that edge:
    - mem_req←0 and err_timeout←1.
    - The MEM/WB register loads a bubble: ni_out=1, wm_out=0, wb_data=0, wbs_out=0.
  - In ACCESS without ack and without timeout, counter increments.
- stall is combinational: stall = (IDLE & mem-op slot) | (ACCESS & ~mem_ack & ~timeout).
- Pass-through: in IDLE with a non-memory slot, the MEM/WB register captures every edge: wb_data=ALUresult_in, wm_out=wm_in, wbs_out=wbs_in, ni_out=ni_in. A bubble input (ni_in=1) forces wm_out=0.
- In every stalled cycle, the MEM/WB register loads a bubble (ni_out=1, wm_out=0). This prevents double writeback.
- mem_ack received in IDLE is ignored.
- mem_addr and mem_wdata hold their values until the next request.
- err_timeout is cleared only by rst.

## Timing

- Reset values: FSM=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wbs_out=0, wm_out=0, ni_out=1, wb_data=0, err_timeout=0. stall=0 when the input is not a memory operation.
- Pass-through latency is 1 cycle.
- Memory operation:
  - Issue edge at cycle 0; mem_req is high from cycle 1.
  - If mem_ack arrives in cycle k≥1, the MEM/WB result is valid in cycle k+1 and stall is low in cycle k.
  - The next memory operation can issue on edge k+1.
  - Minimum occupancy is 2 cycles.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles, then drops. stall drops combinationally in the final ACCESS cycle.
- Ack and timeout in the same cycle: the ack wins (normal completion), and err_timeout is not set.
- Asynchronous rst mid-access drops mem_req and stall immediately. A late ack after reset is ignored.

## Test plan

- Pass-through:
  - Stimulus: ni=0, wme=0, mm=0, wm=1, wbs=1, ALUresult=16'h1234.
  - Required: next cycle wb_data=1234, wm_out=1, wbs_out=1, ni_out=0; stall=0 throughout.
- Load, ack 3 cycles after issue:
  - Stimulus: mm=1, wm=1, ALUresult=16'h00A0, mem_rdata=16'hBEEF.
  - Required: mem_req high in cycles 1–3 with mem_we=0 and mem_addr=00A0; stall high in cycles 0–2; ni_out=1 in cycles 1–3; wb_data=BEEF with wm_out=1 in cycle 4.
- Store, ack in first ACCESS cycle:
  - Stimulus: wme=1, ALUresult=16'h4A81, memData=16'h7755, wm=0.
  - Required: mem_we=1, mem_wdata=7755; next cycle wb_data=4A81, wm_out=0, ni_out=0.
- Timeout with TIMEOUT=4:
  - Stimulus: load issued, never acknowledged.
  - Required: mem_req high for exactly 4 cycles; err_timeout=1 afterwards; one bubble in MEM/WB; stall released.
  - Then ack arriving exactly in the 4th cycle: completes normally, err_timeout stays 0.
- Back-to-back memory operations and bubble:
  - Stimulus: two loads in sequence, each acked in its first ACCESS cycle; then ni_in=1 with mm=1.
  - Required: each load takes 2 cycles with no duplicate writeback; the ni_in=1 slot produces no mem_req.
- Reset mid-access:
  - Stimulus: assert rst while in ACCESS; then ack in the following cycle.
  - Required: all outputs at reset values immediately; the ack causes no state change.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack handshake, stalls upstream
// while an access is outstanding, aborts on timeout, and holds the MEM/WB register.
module memory_access_stage #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wbs_in,
   input  logic              wme_in,
   input  logic              mm_in,
   input  logic              wm_in,
   input  logic              ni_in,
   input  logic [DATA_W-1:0] ALUresult_in,
   input  logic [DATA_W-1:0] memData_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              wbs_out,
   output logic              wm_out,
   output logic              ni_out,
   output logic [DATA_W-1:0] wb_data,
   output logic              err_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               mem_op, timeout, done;

   logic               req_nxt, we_nxt, err_nxt;
   logic [DATA_W-1:0]  addr_nxt, wdata_nxt, wb_data_nxt;
   logic               wbs_nxt, wm_nxt, ni_nxt;

   assign mem_op  = ~ni_in & (wme_in | mm_in);
   assign done    = (state == ACCESS) & mem_ack;
   // Ack in the last allowed cycle wins over the abort.
   assign timeout = (state == ACCESS) & ~mem_ack & (count == CNT_W'(TIMEOUT - 1));
   // Gated by rst so an async reset releases the pipeline immediately.
   assign stall   = ~rst & (((state == IDLE) & mem_op) |
                            ((state == ACCESS) & ~mem_ack & ~timeout));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_op) state_nxt = ACCESS;
         ACCESS:  if (done || timeout) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; default is hold plus a MEM/WB bubble
   always_comb begin
      req_nxt     = mem_req;
      we_nxt      = mem_we;
      addr_nxt    = mem_addr;
      wdata_nxt   = mem_wdata;
      count_nxt   = count;
      err_nxt     = err_timeout;
      wbs_nxt     = 1'b0;
      wm_nxt      = 1'b0;
      ni_nxt      = 1'b1;
      wb_data_nxt = '0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               req_nxt   = 1'b1;
               we_nxt    = wme_in;
               addr_nxt  = ALUresult_in;
               wdata_nxt = memData_in;
               count_nxt = '0;
            end else begin
               wb_data_nxt = ALUresult_in;
               wm_nxt      = wm_in & ~ni_in;
               wbs_nxt     = wbs_in;
               ni_nxt      = ni_in;
            end
         end
         ACCESS: begin
            if (done) begin
               req_nxt     = 1'b0;
               wb_data_nxt = mem_we ? ALUresult_in : mem_rdata;
               wm_nxt      = wm_in;
               wbs_nxt     = wbs_in;
               ni_nxt      = 1'b0;
            end else if (timeout) begin
               req_nxt = 1'b0;
               err_nxt = 1'b1;
            end else begin
               count_nxt = count + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Output and MEM/WB registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         err_timeout <= 1'b0;
         wbs_out     <= 1'b0;
         wm_out      <= 1'b0;
         ni_out      <= 1'b1;
         wb_data     <= '0;
      end else begin
         count       <= count_nxt;
         mem_req     <= req_nxt;
         mem_we      <= we_nxt;
         mem_addr    <= addr_nxt;
         mem_wdata   <= wdata_nxt;
         err_timeout <= err_nxt;
         wbs_out     <= wbs_nxt;
         wm_out      <= wm_nxt;
         ni_out      <= ni_nxt;
         wb_data     <= wb_data_nxt;
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with TIMEOUT=4; checks outputs #1 after edges.
module tb_memory_access_stage;

   logic        clk, rst;
   logic        wbs_in, wme_in, mm_in, wm_in, ni_in;
   logic [15:0] ALUresult_in, memData_in, mem_rdata;
   logic        mem_ack;
   logic        mem_req, mem_we, stall, wbs_out, wm_out, ni_out, err_timeout;
   logic [15:0] mem_addr, mem_wdata, wb_data;

   int total = 0;
   int bad   = 0;

   memory_access_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in), .ni_in(ni_in),
      .ALUresult_in(ALUresult_in), .memData_in(memData_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
      .wbs_out(wbs_out), .wm_out(wm_out), .ni_out(ni_out), .wb_data(wb_data),
      .err_timeout(err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wbs_in = 0; wme_in = 0; mm_in = 0; wm_in = 0; ni_in = 1;
      ALUresult_in = '0; memData_in = '0; mem_rdata = '0; mem_ack = 0;
   endtask

   task automatic load_in(input logic [15:0] addr, input logic [15:0] rdata);
      wbs_in = 1; wme_in = 0; mm_in = 1; wm_in = 1; ni_in = 0;
      ALUresult_in = addr; mem_rdata = rdata; mem_ack = 0;
   endtask

   initial begin
      idle_in();
      rst = 1;
      #12;
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_ni", 32'(ni_out), 1);
      chk("rst_wm", 32'(wm_out), 0);
      chk("rst_wbs", 32'(wbs_out), 0);
      chk("rst_wb", 32'(wb_data), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_stall", 32'(stall), 0);
      rst = 0;

      // pass-through
      ni_in = 0; wm_in = 1; wbs_in = 1; ALUresult_in = 16'h1234;
      #1 chk("pt_stall0", 32'(stall), 0);
      tick();
      chk("pt_wb", 32'(wb_data), 32'h1234);
      chk("pt_wm", 32'(wm_out), 1);
      chk("pt_wbs", 32'(wbs_out), 1);
      chk("pt_ni", 32'(ni_out), 0);
      chk("pt_stall1", 32'(stall), 0);
      // bubble input suppresses the register write
      ni_in = 1; mm_in = 1; ALUresult_in = 16'h5555;
      tick();
      chk("pt_bub_ni", 32'(ni_out), 1);
      chk("pt_bub_wm", 32'(wm_out), 0);
      chk("pt_bub_req", 32'(mem_req), 0);

      // load acked in cycle 3
      load_in(16'h00A0, 16'hBEEF);
      #1 chk("ld_stall_c0", 32'(stall), 1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         if (c == 3) begin
            mem_ack = 1;
            #1;
         end
         chk($sformatf("ld_req_c%0d", c), 32'(mem_req), 1);
         chk($sformatf("ld_we_c%0d", c), 32'(mem_we), 0);
         chk($sformatf("ld_addr_c%0d", c), 32'(mem_addr), 32'h00A0);
         chk($sformatf("ld_ni_c%0d", c), 32'(ni_out), 1);
         chk($sformatf("ld_stall_c%0d", c), 32'(stall), (c < 3) ? 1 : 0);
      end
      tick();
      idle_in();
      chk("ld_wb", 32'(wb_data), 32'hBEEF);
      chk("ld_wm", 32'(wm_out), 1);
      chk("ld_ni", 32'(ni_out), 0);
      chk("ld_req_off", 32'(mem_req), 0);

      // store acked in first access cycle
      wme_in = 1; mm_in = 0; wm_in = 0; ni_in = 0;
      ALUresult_in = 16'h4A81; memData_in = 16'h7755;
      #1 chk("st_stall_c0", 32'(stall), 1);
      tick();
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_wdata", 32'(mem_wdata), 32'h7755);
      chk("st_addr", 32'(mem_addr), 32'h4A81);
      mem_ack = 1;
      #1 chk("st_stall_ack", 32'(stall), 0);
      tick();
      idle_in();
      chk("st_wb", 32'(wb_data), 32'h4A81);
      chk("st_wm", 32'(wm_out), 0);
      chk("st_ni", 32'(ni_out), 0);
      chk("st_req_off", 32'(mem_req), 0);
      chk("st_addr_hold", 32'(mem_addr), 32'h4A81);

      // timeout: no ack, req high for 4 cycles
      load_in(16'h0055, 16'h0000);
      for (int c = 1; c <= 4; c++) begin
         tick();
         #1;
         chk($sformatf("to_req_c%0d", c), 32'(mem_req), 1);
         chk($sformatf("to_stall_c%0d", c), 32'(stall), (c < 4) ? 1 : 0);
         chk($sformatf("to_err_c%0d", c), 32'(err_timeout), 0);
      end
      tick();
      idle_in();
      #1;
      chk("to_req_off", 32'(mem_req), 0);
      chk("to_err", 32'(err_timeout), 1);
      chk("to_ni", 32'(ni_out), 1);
      chk("to_wm", 32'(wm_out), 0);
      chk("to_wb", 32'(wb_data), 0);
      chk("to_stall", 32'(stall), 0);
      tick();
      chk("to_err_sticky", 32'(err_timeout), 1);

      // ack in the final allowed cycle wins over timeout
      rst = 1;
      #2;
      chk("rst2_err", 32'(err_timeout), 0);
      rst = 0;
      load_in(16'h0066, 16'hCAFE);
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) mem_ack = 1;
      end
      #1 chk("late_stall", 32'(stall), 0);
      tick();
      idle_in();
      chk("late_wb", 32'(wb_data), 32'hCAFE);
      chk("late_ni", 32'(ni_out), 0);
      chk("late_err", 32'(err_timeout), 0);
      chk("late_req", 32'(mem_req), 0);

      // back-to-back loads, then a bubble with mm set
      load_in(16'h0010, 16'h1111);
      tick();
      mem_ack = 1;
      #1;
      chk("bb_addr_a", 32'(mem_addr), 32'h0010);
      chk("bb_stall_a", 32'(stall), 0);
      tick();
      load_in(16'h0020, 16'h2222);
      #1;
      chk("bb_wb_a", 32'(wb_data), 32'h1111);
      chk("bb_ni_a", 32'(ni_out), 0);
      chk("bb_stall_b0", 32'(stall), 1);
      tick();
      chk("bb_req_b", 32'(mem_req), 1);
      chk("bb_addr_b", 32'(mem_addr), 32'h0020);
      chk("bb_nodup", 32'(ni_out), 1);
      chk("bb_nodup_wm", 32'(wm_out), 0);
      mem_ack = 1;
      tick();
      mem_ack = 0; ni_in = 1; mm_in = 1; ALUresult_in = 16'h0000;
      #1;
      chk("bb_wb_b", 32'(wb_data), 32'h2222);
      chk("bb_ni_b", 32'(ni_out), 0);
      chk("bb_bub_stall", 32'(stall), 0);
      tick();
      chk("bb_bub_req", 32'(mem_req), 0);
      chk("bb_bub_ni", 32'(ni_out), 1);
      chk("bb_bub_wm", 32'(wm_out), 0);

      // async reset mid-access; late ack ignored
      load_in(16'h0030, 16'hDEAD);
      tick();
      chk("ra_req_pre", 32'(mem_req), 1);
      #2 rst = 1;
      #1;
      chk("ra_req", 32'(mem_req), 0);
      chk("ra_stall", 32'(stall), 0);
      chk("ra_addr", 32'(mem_addr), 0);
      chk("ra_ni", 32'(ni_out), 1);
      idle_in();
      rst = 0;
      tick();
      mem_ack = 1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 0;
      chk("ra_ack_req", 32'(mem_req), 0);
      chk("ra_ack_ni", 32'(ni_out), 1);
      chk("ra_ack_wb", 32'(wb_data), 0);
      chk("ra_ack_wm", 32'(wm_out), 0);
      chk("ra_ack_stall", 32'(stall), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
